// File: rtl/pc_update_if.sv
//------------------------------------------------------------------------------
// pc_update_if : branch-resolution inputs and fetch-request outputs of the PC unit
// Revision     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface pc_update_if #(
  parameter int XLEN = 32
);
  logic            br_valid;
  logic            take_branch;
  logic            is_jump;
  logic [XLEN-1:0] br_target;
  logic            stall;
  logic            fetch_ready;
  logic [XLEN-1:0] pc;
  logic            pc_valid;
  logic            flush;
  logic            redirect;
`ifdef PC_MISALIGN_TRAP_EN
  logic            misalign_trap;
`endif

  modport master (
    input  br_valid, take_branch, is_jump, br_target, stall, fetch_ready,
    output pc, pc_valid, flush, redirect
`ifdef PC_MISALIGN_TRAP_EN
    , output misalign_trap
`endif
  );

  modport slave (
    output br_valid, take_branch, is_jump, br_target, stall, fetch_ready,
    input  pc, pc_valid, flush, redirect
`ifdef PC_MISALIGN_TRAP_EN
    , input misalign_trap
`endif
  );
endinterface

`default_nettype wire

// File: rtl/pc_update_unit.sv
//------------------------------------------------------------------------------
// pc_update_unit : RV32 program counter with branch redirect and timed flush
//                  (optional PC_MISALIGN_TRAP_EN: trap and halt on bad target)
// Revision       : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module pc_update_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_PC     = '0,
  parameter int              FLUSH_CYCLES = 2
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  pc_update_if.master bus
);

  localparam int              C_CNT_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [C_CNT_W-1:0] C_CNT_INIT = C_CNT_W'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1
`ifdef PC_MISALIGN_TRAP_EN
    , ST_HALT = 2'd2
`endif
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [XLEN-1:0]    r_pc, w_pc_nxt;
  logic               r_pc_valid, w_pc_valid_nxt;
  logic               r_flush, w_flush_nxt;
  logic               r_redirect, w_redirect_nxt;
  logic [C_CNT_W-1:0] r_cnt, w_cnt_nxt;
`ifdef PC_MISALIGN_TRAP_EN
  logic               r_trap, w_trap_nxt;
`endif

  logic w_taken;
  logic w_unused_tgt_bits;

  assign w_taken           = bus.br_valid & (bus.take_branch | bus.is_jump);
  assign w_unused_tgt_bits = ^bus.br_target[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_RUN;
      r_pc       <= RESET_PC;
      r_pc_valid <= 1'b0;
      r_flush    <= 1'b0;
      r_redirect <= 1'b0;
      r_cnt      <= '0;
`ifdef PC_MISALIGN_TRAP_EN
      r_trap     <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_pc_valid <= w_pc_valid_nxt;
      r_flush    <= w_flush_nxt;
      r_redirect <= w_redirect_nxt;
      r_cnt      <= w_cnt_nxt;
`ifdef PC_MISALIGN_TRAP_EN
      r_trap     <= w_trap_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_pc_valid_nxt = r_pc_valid;
    w_flush_nxt    = r_flush;
    w_redirect_nxt = 1'b0;
    w_cnt_nxt      = r_cnt;
`ifdef PC_MISALIGN_TRAP_EN
    w_trap_nxt     = 1'b0;
`endif

    case (r_state)
      ST_RUN: begin
        w_pc_valid_nxt = 1'b1;
        w_flush_nxt    = 1'b0;
        if (w_taken) begin
`ifdef PC_MISALIGN_TRAP_EN
          if (bus.br_target[1]) begin
            w_trap_nxt     = 1'b1;
            w_flush_nxt    = 1'b1;
            w_cnt_nxt      = C_CNT_INIT;
            w_pc_valid_nxt = 1'b0;
            w_state_nxt    = ST_HALT;
          end else
`endif
          begin
            // Low two bits forced to zero: fetch is always word aligned.
            w_pc_nxt       = {bus.br_target[XLEN-1:2], 2'b00};
            w_redirect_nxt = 1'b1;
            w_flush_nxt    = 1'b1;
            w_cnt_nxt      = C_CNT_INIT;
            w_state_nxt    = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
          end
        end else if (bus.stall) begin
          w_pc_nxt = r_pc;
        end else if (r_pc_valid && bus.fetch_ready) begin
          w_pc_nxt = r_pc + XLEN'(4);
        end
      end

      ST_FLUSH: begin
        // Branch inputs here belong to a squashed instruction.
        w_pc_valid_nxt = 1'b1;
        if (bus.fetch_ready && !bus.stall) begin
          w_pc_nxt = r_pc + XLEN'(4);
        end
        if (r_cnt == '0) begin
          w_state_nxt = ST_RUN;
          w_flush_nxt = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt - C_CNT_W'(1);
        end
      end

`ifdef PC_MISALIGN_TRAP_EN
      ST_HALT: begin
        w_pc_valid_nxt = 1'b0;
        if (r_cnt == '0) begin
          w_flush_nxt = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt - C_CNT_W'(1);
        end
      end
`endif

      default: begin
        w_state_nxt = ST_RUN;
        w_flush_nxt = 1'b0;
      end
    endcase
  end

  assign bus.pc       = r_pc;
  assign bus.pc_valid = r_pc_valid;
  assign bus.flush    = r_flush;
  assign bus.redirect = r_redirect;
`ifdef PC_MISALIGN_TRAP_EN
  assign bus.misalign_trap = r_trap;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pc_update_unit.sv
//------------------------------------------------------------------------------
// tb_pc_update_unit : directed vector bench for pc_update_unit
// Revision          : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pc_update_unit;

  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0100;
  localparam int          NVEC     = 21;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  pc_update_if #(.XLEN(XLEN)) bus ();

  pc_update_unit #(
    .XLEN        (XLEN),
    .RESET_PC    (RESET_PC),
    .FLUSH_CYCLES(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        bv;
    logic        tb;
    logic        ij;
    logic        stall;
    logic        fr;
    logic [31:0] tgt;
    logic [31:0] e_pc;
    logic        e_valid;
    logic        e_flush;
    logic        e_redir;
  } vec_t;

  vec_t vec [NVEC];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic drive(input logic bv, input logic tb, input logic ij,
                       input logic stall, input logic fr, input logic [31:0] tgt);
    bus.br_valid    = bv;
    bus.take_branch = tb;
    bus.is_jump     = ij;
    bus.stall       = stall;
    bus.fetch_ready = fr;
    bus.br_target   = tgt;
  endtask

  task automatic chk_all(input string tag, input logic [31:0] pc, input logic v,
                         input logic f, input logic r);
    chk({tag, ".pc"},       bus.pc,                pc);
    chk({tag, ".pc_valid"}, {31'd0, bus.pc_valid}, {31'd0, v});
    chk({tag, ".flush"},    {31'd0, bus.flush},    {31'd0, f});
    chk({tag, ".redirect"}, {31'd0, bus.redirect}, {31'd0, r});
  endtask

  initial begin
    //           bv    tb    ij    stl   fr    target        exp pc        v     f     r
    vec[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h100,      1'b1, 1'b0, 1'b0};
    vec[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        32'h104,      1'b1, 1'b0, 1'b0};
    vec[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        32'h108,      1'b1, 1'b0, 1'b0};
    vec[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        32'h10C,      1'b1, 1'b0, 1'b0};
    vec[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0,        32'h10C,      1'b1, 1'b0, 1'b0};
    vec[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h10C,      1'b1, 1'b0, 1'b0};
    vec[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h200,      32'h200,      1'b1, 1'b1, 1'b1};
    vec[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h300,      32'h204,      1'b1, 1'b1, 1'b0};
    vec[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        32'h208,      1'b1, 1'b0, 1'b0};
    vec[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h500,      32'h20C,      1'b1, 1'b0, 1'b0};
    vec[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h401,      32'h400,      1'b1, 1'b1, 1'b1};
    vec[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0,        32'h400,      1'b1, 1'b1, 1'b0};
    vec[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        32'h404,      1'b1, 1'b0, 1'b0};
    vec[13] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h600,      32'h600,      1'b1, 1'b1, 1'b1};
    vec[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h600,      1'b1, 1'b1, 1'b0};
    vec[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h600,      1'b1, 1'b0, 1'b0};
    vec[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h700,      32'h604,      1'b1, 1'b0, 1'b0};
    vec[17] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFC, 32'hFFFFFFFC, 1'b1, 1'b1, 1'b1};
    vec[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'hFFFFFFFC, 1'b1, 1'b1, 1'b0};
    vec[19] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'hFFFFFFFC, 1'b1, 1'b0, 1'b0};
    vec[20] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0};

    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    #12;
    chk_all("reset", RESET_PC, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      drive(vec[i].bv, vec[i].tb, vec[i].ij, vec[i].stall, vec[i].fr, vec[i].tgt);
      @(posedge clk); #1;
      chk_all($sformatf("vec%0d", i), vec[i].e_pc, vec[i].e_valid, vec[i].e_flush, vec[i].e_redir);
    end

    // Asynchronous reset in the middle of a flush window.
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h800);
    @(posedge clk); #1;
    chk_all("pre_rst", 32'h800, 1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    rst_n = 1'b0;
    #1;
    chk_all("mid_rst", RESET_PC, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk_all("held_rst", RESET_PC, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_all("post_rst", RESET_PC, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk_all("post_rst2", RESET_PC, 1'b1, 1'b0, 1'b0);

`ifdef PC_MISALIGN_TRAP_EN
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h202);
    @(posedge clk); #1;
    chk_all("trap0", RESET_PC, 1'b0, 1'b1, 1'b0);
    chk("trap0.misalign_trap", {31'd0, bus.misalign_trap}, 32'd1);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h300);
    @(posedge clk); #1;
    chk_all("trap1", RESET_PC, 1'b0, 1'b1, 1'b0);
    chk("trap1.misalign_trap", {31'd0, bus.misalign_trap}, 32'd0);
    @(posedge clk); #1;
    chk_all("trap2", RESET_PC, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    @(posedge clk); #1;
    chk_all("trap3", RESET_PC, 1'b0, 1'b0, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
